// File: rtl/busca_media_pixels_pkg.sv
// Shared definitions for the fetch-and-reduce stage: algorithm/zoom codes,
// FSM encoding, default frame geometry and the read-plan decoder.
package busca_media_pixels_pkg;

    localparam int LARGURA_DEF = 320;
    localparam int ALTURA_DEF  = 240;
    localparam int COORD_W     = 10;
    localparam int N_PARES     = 16;

    localparam logic [3:0] ALG_NNI_ZIN  = 4'b0001;
    localparam logic [3:0] ALG_REP      = 4'b0010;
    localparam logic [3:0] ALG_NNI_ZOUT = 4'b0100;
    localparam logic [3:0] ALG_MEDIA    = 4'b1000;

    localparam logic [1:0] ZOOM_1X = 2'b00;
    localparam logic [1:0] ZOOM_2X = 2'b01;
    localparam logic [1:0] ZOOM_4X = 2'b10;

    typedef enum logic [2:0] {
        OCIOSO  = 3'b001,
        LEITURA = 3'b010,
        ESPERA  = 3'b100
    } estado_t;

    typedef struct packed {
        logic [3:0] ultimo_idx;
        logic [2:0] shift;
    } plano_t;

    // Only block-average with 2x/4x zoom reads more than one pixel.
    function automatic plano_t calc_plano(input logic [3:0] alg, input logic [1:0] zoom);
        plano_t p;
        p.ultimo_idx = 4'd0;
        p.shift      = 3'd0;
        if (alg == ALG_MEDIA) begin
            case (zoom)
                ZOOM_2X: begin
                    p.ultimo_idx = 4'd3;
                    p.shift      = 3'd2;
                end
                ZOOM_4X: begin
                    p.ultimo_idx = 4'd15;
                    p.shift      = 3'd4;
                end
                default: begin
                    p.ultimo_idx = 4'd0;
                    p.shift      = 3'd0;
                end
            endcase
        end else begin
            p.ultimo_idx = 4'd0;
            p.shift      = 3'd0;
        end
        return p;
    endfunction

endpackage

// File: rtl/busca_media_pixels_calc_endereco.sv
// Combinational (x, y) -> frame RAM address, with an out-of-frame flag.
module calc_endereco
    import busca_media_pixels_pkg::*;
#(
    parameter int LARGURA = LARGURA_DEF,
    parameter int ALTURA  = ALTURA_DEF,
    parameter int ADDR_W  = 17
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic               fora,
    output logic [ADDR_W-1:0]  addr
);

    localparam int FULL_W = 2 * COORD_W + 1;
    localparam logic [COORD_W-1:0] LARG_C = COORD_W'(LARGURA);
    localparam logic [COORD_W-1:0] ALT_C  = COORD_W'(ALTURA);

    logic [FULL_W-1:0] full_s;

    // Row-major address at full width, truncated to the RAM address width.
    always_comb begin
        full_s = FULL_W'(y) * FULL_W'(LARGURA) + FULL_W'(x);
        addr   = full_s[ADDR_W-1:0];
        fora   = (x >= LARG_C) || (y >= ALT_C);
    end

endmodule

// File: rtl/busca_media_pixels.sv
// Fetch-and-reduce stage: reads 1, 4 or 16 source pixels per start and emits
// their truncated mean (or a pass-through pixel) to the destination writer.
module busca_media_pixels
    import busca_media_pixels_pkg::*;
#(
    parameter int LARGURA = LARGURA_DEF,
    parameter int ALTURA  = ALTURA_DEF,
    parameter int ADDR_W  = 17,
    parameter int PIXEL_W = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [3:0]                   entrada_algoritmo,
    input  logic [1:0]                   entrada_zoom,
    input  logic [N_PARES*COORD_W-1:0]   x_fonte_bus,
    input  logic [N_PARES*COORD_W-1:0]   y_fonte_bus,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic                         mem_rd,
    input  logic [PIXEL_W-1:0]           mem_dado,
    output logic [PIXEL_W-1:0]           pixel_out,
    output logic                         pixel_valid,
    output logic                         busy
);

    localparam int BUS_W  = N_PARES * COORD_W;
    localparam int SOMA_W = PIXEL_W + 4;

    estado_t              estado_q, estado_d;
    logic [3:0]           idx_q, idx_d;
    logic [3:0]           ultimo_q, ultimo_d;
    logic [2:0]           shift_q, shift_d;
    logic [BUS_W-1:0]     x_bus_q, x_bus_d;
    logic [BUS_W-1:0]     y_bus_q, y_bus_d;
    logic [SOMA_W-1:0]    soma_q, soma_d;
    logic                 rd_dly_q, rd_dly_d;
    logic                 mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [PIXEL_W-1:0]   pixel_out_q, pixel_out_d;
    logic                 pixel_valid_q, pixel_valid_d;

    logic [3:0]           idx_busca_s;
    logic [BUS_W-1:0]     x_sel_bus_s, y_sel_bus_s;
    logic [COORD_W-1:0]   x_s, y_s;
    logic                 fora_s;
    logic [ADDR_W-1:0]    addr_s;
    logic [SOMA_W-1:0]    contrib_s, total_s, media_s;
    plano_t               plano_s;

    // Address is registered, so the pair looked up is the one issued next cycle;
    // at start that is pair 0 taken straight from the input buses.
    always_comb begin
        if (estado_q == LEITURA) begin
            idx_busca_s = idx_q + 4'd1;
            x_sel_bus_s = x_bus_q;
            y_sel_bus_s = y_bus_q;
        end else begin
            idx_busca_s = 4'd0;
            x_sel_bus_s = x_fonte_bus;
            y_sel_bus_s = y_fonte_bus;
        end
        x_s = x_sel_bus_s[idx_busca_s*COORD_W +: COORD_W];
        y_s = y_sel_bus_s[idx_busca_s*COORD_W +: COORD_W];
    end

    calc_endereco #(
        .LARGURA (LARGURA),
        .ALTURA  (ALTURA),
        .ADDR_W  (ADDR_W)
    ) u_calc_endereco (
        .x    (x_s),
        .y    (y_s),
        .fora (fora_s),
        .addr (addr_s)
    );

    // Next-state, read issue and accumulation.
    always_comb begin
        plano_s       = calc_plano(entrada_algoritmo, entrada_zoom);
        contrib_s     = rd_dly_q ? {4'b0000, mem_dado} : {SOMA_W{1'b0}};
        total_s       = soma_q + contrib_s;
        media_s       = total_s >> shift_q;
        estado_d      = estado_q;
        idx_d         = idx_q;
        ultimo_d      = ultimo_q;
        shift_d       = shift_q;
        x_bus_d       = x_bus_q;
        y_bus_d       = y_bus_q;
        soma_d        = total_s;
        rd_dly_d      = mem_rd_q;
        mem_rd_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        pixel_out_d   = pixel_out_q;
        pixel_valid_d = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (start) begin
                    ultimo_d   = plano_s.ultimo_idx;
                    shift_d    = plano_s.shift;
                    x_bus_d    = x_fonte_bus;
                    y_bus_d    = y_fonte_bus;
                    idx_d      = 4'd0;
                    soma_d     = {SOMA_W{1'b0}};
                    mem_rd_d   = ~fora_s;
                    mem_addr_d = addr_s;
                    estado_d   = LEITURA;
                end else begin
                    estado_d = OCIOSO;
                end
            end
            LEITURA: begin
                if (idx_q == ultimo_q) begin
                    estado_d = ESPERA;
                end else begin
                    idx_d      = idx_q + 4'd1;
                    mem_rd_d   = ~fora_s;
                    mem_addr_d = addr_s;
                end
            end
            ESPERA: begin
                pixel_out_d   = media_s[PIXEL_W-1:0];
                pixel_valid_d = 1'b1;
                estado_d      = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q      <= OCIOSO;
            idx_q         <= 4'd0;
            ultimo_q      <= 4'd0;
            shift_q       <= 3'd0;
            x_bus_q       <= {BUS_W{1'b0}};
            y_bus_q       <= {BUS_W{1'b0}};
            soma_q        <= {SOMA_W{1'b0}};
            rd_dly_q      <= 1'b0;
            mem_rd_q      <= 1'b0;
            mem_addr_q    <= {ADDR_W{1'b0}};
            pixel_out_q   <= {PIXEL_W{1'b0}};
            pixel_valid_q <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            idx_q         <= idx_d;
            ultimo_q      <= ultimo_d;
            shift_q       <= shift_d;
            x_bus_q       <= x_bus_d;
            y_bus_q       <= y_bus_d;
            soma_q        <= soma_d;
            rd_dly_q      <= rd_dly_d;
            mem_rd_q      <= mem_rd_d;
            mem_addr_q    <= mem_addr_d;
            pixel_out_q   <= pixel_out_d;
            pixel_valid_q <= pixel_valid_d;
        end
    end

    assign mem_rd      = mem_rd_q;
    assign mem_addr    = mem_addr_q;
    assign pixel_out   = pixel_out_q;
    assign pixel_valid = pixel_valid_q;
    assign busy        = (estado_q != OCIOSO);

endmodule

// File: tb/tb_busca_media_pixels.sv
// Self-checking bench for busca_media_pixels: directed table, hand-written
// handshake/reset sequences and randomized ops against a frame-level model.
module tb_busca_media_pixels;

    localparam int LARG = 320;
    localparam int ALT  = 240;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   alg;
    logic [1:0]   zoom;
    logic [159:0] xb, yb;
    logic [16:0]  mem_addr;
    logic         mem_rd;
    logic [7:0]   mem_dado;
    logic [7:0]   pixel_out;
    logic         pixel_valid;
    logic         busy;

    logic [7:0] ram [0:131071];

    int errors = 0;
    int checks = 0;

    int exp_cyc[$], exp_addr[$], got_cyc[$], got_addr[$];
    int last_pix, last_lat, exp_pix, exp_n;

    typedef struct {
        logic [3:0]      alg;
        logic [1:0]      zoom;
        int              x0, y0, oor;
        logic [3:0][7:0] v;
        logic [7:0]      fill;
        int              exp_pix, exp_n;
    } vec_t;

    vec_t tbl[11];

    busca_media_pixels dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .entrada_algoritmo (alg),
        .entrada_zoom      (zoom),
        .x_fonte_bus       (xb),
        .y_fonte_bus       (yb),
        .mem_addr          (mem_addr),
        .mem_rd            (mem_rd),
        .mem_dado          (mem_dado),
        .pixel_out         (pixel_out),
        .pixel_valid       (pixel_valid),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    // Frame RAM: data one cycle after the strobe, garbage otherwise.
    always @(posedge clk) mem_dado <= mem_rd ? ram[mem_addr] : 8'($urandom);

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] a, input logic [1:0] z, input int x0, y0, oor,
                                input logic [7:0] v0, v1, v2, v3, fill, input int ep, en);
        vec_t r;
        r.alg = a; r.zoom = z; r.x0 = x0; r.y0 = y0; r.oor = oor;
        r.v[0] = v0; r.v[1] = v1; r.v[2] = v2; r.v[3] = v3;
        r.fill = fill; r.exp_pix = ep; r.exp_n = en;
        return r;
    endfunction

    // Reference: which pairs get read, and the mean over N slots.
    task automatic model(input logic [3:0] a, input logic [1:0] z, input logic [159:0] xs, ys);
        int sum, x, y, ad;
        exp_n = (a == 4'b1000 && z == 2'b01) ? 4 : (a == 4'b1000 && z == 2'b10) ? 16 : 1;
        sum = 0;
        exp_cyc.delete();
        exp_addr.delete();
        for (int i = 0; i < exp_n; i++) begin
            x = int'(xs[i*10 +: 10]);
            y = int'(ys[i*10 +: 10]);
            if (x < LARG && y < ALT) begin
                ad = (y * LARG + x) % 131072;
                sum += int'(ram[ad]);
                exp_cyc.push_back(i + 1);
                exp_addr.push_back(ad);
            end
        end
        exp_pix = sum / exp_n;
    endtask

    // Called at a negedge; start is sampled at the following posedge (T).
    task automatic run_op(input logic [3:0] a, input logic [1:0] z, input logic [159:0] xs, ys,
                          input int glitch_k, input string tag);
        model(a, z, xs, ys);
        alg = a; zoom = z; xb = xs; yb = ys; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        xb = {$urandom, $urandom, $urandom, $urandom, $urandom};
        yb = {$urandom, $urandom, $urandom, $urandom, $urandom};
        alg = 4'($urandom); zoom = 2'($urandom);
        got_cyc.delete();
        got_addr.delete();
        last_lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 1) check({tag, " busy_first"}, int'(busy), 1);
            if (mem_rd) begin
                got_cyc.push_back(k);
                got_addr.push_back(int'(mem_addr));
            end
            if (pixel_valid) begin
                last_lat = k;
                break;
            end
            start = (k == glitch_k);
            @(negedge clk);
        end
        start = 1'b0;
        last_pix = int'(pixel_out);
        check({tag, " latency"}, last_lat, exp_n + 2);
        check({tag, " pixel"}, last_pix, exp_pix);
        check({tag, " busy_at_valid"}, int'(busy), 0);
        check({tag, " nreads"}, got_addr.size(), exp_addr.size());
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            check($sformatf("%s rd%0d_addr", tag, i), got_addr[i], exp_addr[i]);
            check($sformatf("%s rd%0d_cycle", tag, i), got_cyc[i], exp_cyc[i]);
        end
    endtask

    task automatic build_vec(input int t, output logic [159:0] xs, ys);
        logic [9:0] xi, yi;
        for (int i = 0; i < 16; i++) begin
            xi = 10'(tbl[t].x0 + i);
            yi = 10'(tbl[t].y0);
            if (i == tbl[t].oor) begin
                xi = 10'd320;
                yi = 10'd0;
            end
            xs[i*10 +: 10] = xi;
            ys[i*10 +: 10] = yi;
            if (xi < 10'd320 && yi < 10'd240)
                ram[int'(yi) * LARG + int'(xi)] = (i < 4) ? tbl[t].v[i] : tbl[t].fill;
        end
    endtask

    initial begin
        logic [159:0] xs, ys;
        logic [3:0]   ra;
        int           nrd, nval;

        reset = 1'b1; start = 1'b0; alg = 4'd0; zoom = 2'd0; xb = 160'd0; yb = 160'd0;
        for (int i = 0; i < 131072; i++) ram[i] = 8'($urandom);

        tbl[0]  = mk(4'b0001, 2'b00,   5,   2, -1, 8'h7A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7A, 1);
        tbl[1]  = mk(4'b1000, 2'b01,  10,   3, -1, 8'd10, 8'd20, 8'd30, 8'd41, 8'd0,  25,    4);
        tbl[2]  = mk(4'b1000, 2'b10, 100,  50, -1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 255,   16);
        tbl[3]  = mk(4'b1000, 2'b01,  40,   7,  2, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 75, 4);
        tbl[4]  = mk(4'b1000, 2'b11,  20,   9, -1, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h33, 1);
        tbl[5]  = mk(4'b0011, 2'b01,  30,   9, -1, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h44, 1);
        tbl[6]  = mk(4'b0100, 2'b10,  50,   9, -1, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 1);
        tbl[7]  = mk(4'b1000, 2'b10, 200, 100, -1, 8'd1,  8'd2,  8'd3,  8'd4,  8'd8,  6,     16);
        tbl[8]  = mk(4'b0010, 2'b00, 319, 239, -1, 8'h99, 8'h00, 8'h00, 8'h00, 8'h00, 8'h99, 1);
        tbl[9]  = mk(4'b1000, 2'b00,   0,   0,  0, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 0,     1);
        tbl[10] = mk(4'b1000, 2'b10,   0,  20,  5, 8'd16, 8'd16, 8'd16, 8'd16, 8'd16, 15,    16);

        repeat (3) @(negedge clk);
        check("rst mem_addr", int'(mem_addr), 0);
        check("rst mem_rd", int'(mem_rd), 0);
        check("rst pixel_out", int'(pixel_out), 0);
        check("rst pixel_valid", int'(pixel_valid), 0);
        check("rst busy", int'(busy), 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors, issued back to back (start lands in each valid cycle).
        for (int t = 0; t < 11; t++) begin
            build_vec(t, xs, ys);
            run_op(tbl[t].alg, tbl[t].zoom, xs, ys, 0, $sformatf("vec%0d", t));
            check($sformatf("vec%0d table_pixel", t), last_pix, tbl[t].exp_pix);
            check($sformatf("vec%0d table_latency", t), last_lat, tbl[t].exp_n + 2);
        end

        // A start pulse mid-operation must be ignored.
        build_vec(1, xs, ys);
        run_op(4'b1000, 2'b01, xs, ys, 2, "glitch");
        check("glitch table_pixel", last_pix, 25);
        @(negedge clk);
        check("glitch no_restart busy", int'(busy), 0);

        // Reset in the middle of a 4x operation.
        build_vec(2, xs, ys);
        alg = 4'b1000; zoom = 2'b10; xb = xs; yb = ys; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstmid busy", int'(busy), 0);
        check("rstmid mem_rd", int'(mem_rd), 0);
        check("rstmid pixel_valid", int'(pixel_valid), 0);
        check("rstmid pixel_out", int'(pixel_out), 0);
        nrd = 0; nval = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            nrd += int'(mem_rd);
            nval += int'(pixel_valid);
        end
        check("rstmid later_reads", nrd, 0);
        check("rstmid later_valids", nval, 0);

        // Randomized operations against the model.
        for (int r = 0; r < 40; r++) begin
            case ($urandom_range(0, 6))
                0: ra = 4'b0001;
                1: ra = 4'b0010;
                2: ra = 4'b0100;
                3, 4, 5: ra = 4'b1000;
                default: ra = 4'($urandom);
            endcase
            for (int i = 0; i < 16; i++) begin
                xs[i*10 +: 10] = ($urandom_range(0, 99) < 10) ? 10'($urandom_range(320, 1023)) : 10'($urandom_range(0, 319));
                ys[i*10 +: 10] = ($urandom_range(0, 99) < 10) ? 10'($urandom_range(240, 1023)) : 10'($urandom_range(0, 239));
            end
            run_op(ra, 2'($urandom_range(0, 3)), xs, ys, 0, $sformatf("rnd%0d", r));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
